// File: rtl/prune_sweeper.sv
// prune_sweeper: sweeps a bit-packed occupancy grid in row memory, clearing cells with < THRESH occupied 8-neighbours.
// Latency: per row 2K load cycles, K eval cycles, 2 cycles per chunk write, 1 shift cycle (zero-wait memory).
// Backpressure: every memory transaction holds req/we/row/col/wdata stable until mem_ack; req drops for a cycle after each ack.
module prune_sweeper #(
   parameter int GRID_W     = 144,
   parameter int TX_W       = 16,
   parameter int N_ROWS     = 140,
   parameter int ROW_AW     = 8,
   parameter int THRESH     = 4,
   parameter int CNT_W      = 16,
   parameter int ITERATE    = 1,
   parameter int MAX_PASSES = 255
) (
   input  logic                            clock,
   input  logic                            reset,
   input  logic                            start,
   output logic                            busy,
   output logic                            done,
   output logic                            mem_req,
   output logic                            mem_we,
   output logic [ROW_AW-1:0]               mem_row,
   output logic [$clog2(GRID_W/TX_W)-1:0]  mem_col,
   output logic [TX_W-1:0]                 mem_wdata,
   input  logic [TX_W-1:0]                 mem_rdata,
   input  logic                            mem_ack,
   output logic [CNT_W-1:0]                pass_removed,
   output logic [CNT_W-1:0]                removed_total,
   output logic [7:0]                      pass_count
);

   localparam int K  = GRID_W / TX_W;
   localparam int CW = $clog2(K);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_PRIME = 3'd1;
   localparam logic [2:0] S_LOAD  = 3'd2;
   localparam logic [2:0] S_EVAL  = 3'd3;
   localparam logic [2:0] S_WRITE = 3'd4;
   localparam logic [2:0] S_SHIFT = 3'd5;
   localparam logic [2:0] S_END   = 3'd6;
   localparam logic [2:0] S_DONE  = 3'd7;

   localparam logic [ROW_AW:0] LAST_ROW = (ROW_AW+1)'(N_ROWS - 1);
   localparam logic [CW-1:0]   LAST_COL = CW'(K - 1);
   localparam logic [4:0]      THR      = 5'(THRESH);

   logic [2:0]        state;
   // Three-row window of original (pre-pass) grid rows: above, current, below.
   logic [GRID_W-1:0] win0;
   logic [GRID_W-1:0] win1;
   logic [GRID_W-1:0] win2;
   logic [ROW_AW:0]   row;
   logic [ROW_AW:0]   row_nxt;
   logic [CW-1:0]     col;
   logic [7:0]        pc_nxt;

   logic [GRID_W+1:0] pad0, pad1, pad2;
   logic [TX_W+1:0]   s0, s1, s2;
   logic [TX_W-1:0]   cur;
   logic [TX_W-1:0]   mask;
   logic [CNT_W-1:0]  pop;
   logic [3:0]        cnt;

   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [CNT_W-1:0] b);
      logic [CNT_W:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[CNT_W] ? '1 : s[CNT_W-1:0];
   endfunction

   assign row_nxt = row + 1'b1;
   assign pc_nxt  = (pass_count == 8'hFF) ? pass_count : pass_count + 8'd1;

   // Prune mask for the current chunk; zero pads give out-of-grid columns, and the slices reach one column into adjacent chunks.
   always_comb begin
      pad0 = {1'b0, win0, 1'b0};
      pad1 = {1'b0, win1, 1'b0};
      pad2 = {1'b0, win2, 1'b0};
      s0   = pad0[int'(col)*TX_W +: TX_W+2];
      s1   = pad1[int'(col)*TX_W +: TX_W+2];
      s2   = pad2[int'(col)*TX_W +: TX_W+2];
      cur  = s1[TX_W:1];
      mask = '0;
      pop  = '0;
      cnt  = '0;
      for (int j = 0; j < TX_W; j++) begin
         cnt = {3'b0, s0[j]} + {3'b0, s0[j+1]} + {3'b0, s0[j+2]}
             + {3'b0, s1[j]} + {3'b0, s1[j+2]}
             + {3'b0, s2[j]} + {3'b0, s2[j+1]} + {3'b0, s2[j+2]};
         mask[j] = s1[j+1] & ({1'b0, cnt} < THR);
         pop = pop + {{(CNT_W-1){1'b0}}, mask[j]};
      end
   end

   // Sweep controller: window loads, chunk evaluation, write-back and pass accounting.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state         <= S_IDLE;
         busy          <= 1'b0;
         done          <= 1'b0;
         mem_req       <= 1'b0;
         mem_we        <= 1'b0;
         mem_row       <= '0;
         mem_col       <= '0;
         mem_wdata     <= '0;
         pass_removed  <= '0;
         removed_total <= '0;
         pass_count    <= '0;
         win0          <= '0;
         win1          <= '0;
         win2          <= '0;
         row           <= '0;
         col           <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  busy          <= 1'b1;
                  removed_total <= '0;
                  pass_count    <= '0;
                  pass_removed  <= '0;
                  row           <= '0;
                  col           <= '0;
                  state         <= S_PRIME;
               end
            end
            S_PRIME: begin
               win0 <= '0;
               if (!mem_req) begin
                  mem_req <= 1'b1;
                  mem_we  <= 1'b0;
                  mem_row <= '0;
                  mem_col <= col;
               end else if (mem_ack) begin
                  mem_req <= 1'b0;
                  win1[int'(col)*TX_W +: TX_W] <= mem_rdata;
                  if (col == LAST_COL) begin
                     col   <= '0;
                     state <= S_LOAD;
                  end else begin
                     col <= col + 1'b1;
                  end
               end
            end
            S_LOAD: begin
               if (row == LAST_ROW) begin
                  // Below the last row the grid reads as empty.
                  win2  <= '0;
                  col   <= '0;
                  state <= S_EVAL;
               end else if (!mem_req) begin
                  mem_req <= 1'b1;
                  mem_we  <= 1'b0;
                  mem_row <= row_nxt[ROW_AW-1:0];
                  mem_col <= col;
               end else if (mem_ack) begin
                  mem_req <= 1'b0;
                  win2[int'(col)*TX_W +: TX_W] <= mem_rdata;
                  if (col == LAST_COL) begin
                     col   <= '0;
                     state <= S_EVAL;
                  end else begin
                     col <= col + 1'b1;
                  end
               end
            end
            S_EVAL: begin
               pass_removed <= sat_add(pass_removed, pop);
               if (mask != '0) begin
                  mem_wdata <= cur & ~mask;
                  mem_row   <= row[ROW_AW-1:0];
                  mem_col   <= col;
                  state     <= S_WRITE;
               end else if (col == LAST_COL) begin
                  col   <= '0;
                  state <= S_SHIFT;
               end else begin
                  col <= col + 1'b1;
               end
            end
            S_WRITE: begin
               if (!mem_req) begin
                  mem_req <= 1'b1;
                  mem_we  <= 1'b1;
               end else if (mem_ack) begin
                  mem_req <= 1'b0;
                  mem_we  <= 1'b0;
                  if (col == LAST_COL) begin
                     col   <= '0;
                     state <= S_SHIFT;
                  end else begin
                     col   <= col + 1'b1;
                     state <= S_EVAL;
                  end
               end
            end
            S_SHIFT: begin
               // Window keeps original rows; the pruned row only went to memory.
               win0  <= win1;
               win1  <= win2;
               row   <= row_nxt;
               state <= (row == LAST_ROW) ? S_END : S_LOAD;
            end
            S_END: begin
               pass_count    <= pc_nxt;
               removed_total <= sat_add(removed_total, pass_removed);
               if ((ITERATE != 0) && (pass_removed != '0) && (int'(pc_nxt) < MAX_PASSES)) begin
                  pass_removed <= '0;
                  row          <= '0;
                  col          <= '0;
                  state        <= S_PRIME;
               end else begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= S_DONE;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_prune_sweeper.sv
// Bench for prune_sweeper: two instances (iterating and single-pass) on a 8x32 grid with a randomized-latency row memory.
// Expected writes and final counters come from a cell-by-cell reference model and are queued before each run.
// A responder serves memory and checks writes in order; a monitor checks counters on each done pulse.
module tb_prune_sweeper;

   localparam int GW   = 32;
   localparam int TW   = 16;
   localparam int NR   = 8;
   localparam int AW   = 4;
   localparam int TH   = 4;
   localparam int CNW  = 16;
   localparam int KC   = GW / TW;
   localparam int MAXP = 255;

   typedef struct {int r; int c; int d;} wr_t;
   typedef struct {int prem; int rtot; int pcnt;} cnt_t;

   logic            clock = 1'b0;
   logic            reset;
   logic            start   [2];
   logic            busy    [2];
   logic            done    [2];
   logic            req     [2];
   logic            we      [2];
   logic [AW-1:0]   row     [2];
   logic [0:0]      col     [2];
   logic [TW-1:0]   wdata   [2];
   logic [TW-1:0]   rdata   [2];
   logic            ack     [2];
   logic [CNW-1:0]  prem    [2];
   logic [CNW-1:0]  rtot    [2];
   logic [7:0]      pcnt    [2];

   logic [GW-1:0]   mem   [2][NR];
   logic [GW-1:0]   gm    [NR];
   logic [GW-1:0]   gsave [NR];

   wr_t  exp_wr  [$];
   cnt_t exp_cnt [$];

   int nchk = 0;
   int nerr = 0;
   int maxd = 0;
   int done_seen = 0;
   int dly [2];

   always #5 clock = ~clock;

   prune_sweeper #(.GRID_W(GW), .TX_W(TW), .N_ROWS(NR), .ROW_AW(AW), .THRESH(TH),
                   .CNT_W(CNW), .ITERATE(1), .MAX_PASSES(MAXP)) dut_it (
      .clock(clock), .reset(reset), .start(start[0]), .busy(busy[0]), .done(done[0]),
      .mem_req(req[0]), .mem_we(we[0]), .mem_row(row[0]), .mem_col(col[0]),
      .mem_wdata(wdata[0]), .mem_rdata(rdata[0]), .mem_ack(ack[0]),
      .pass_removed(prem[0]), .removed_total(rtot[0]), .pass_count(pcnt[0]));

   prune_sweeper #(.GRID_W(GW), .TX_W(TW), .N_ROWS(NR), .ROW_AW(AW), .THRESH(TH),
                   .CNT_W(CNW), .ITERATE(0), .MAX_PASSES(MAXP)) dut_one (
      .clock(clock), .reset(reset), .start(start[1]), .busy(busy[1]), .done(done[1]),
      .mem_req(req[1]), .mem_we(we[1]), .mem_row(row[1]), .mem_col(col[1]),
      .mem_wdata(wdata[1]), .mem_rdata(rdata[1]), .mem_ack(ack[1]),
      .pass_removed(prem[1]), .removed_total(rtot[1]), .pass_count(pcnt[1]));

   task automatic chk(input string nm, input int act, input int exp);
      nchk++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic int occ(input int r, input int c);
      if (r < 0 || r >= NR || c < 0 || c >= GW) return 0;
      return int'(gm[r][c]);
   endfunction

   // Reference: apply the survival rule to every cell against the pre-pass grid, pass after pass.
   task automatic model(input int iter);
      int passes, total, removed, n;
      logic [GW-1:0] gn [NR];
      wr_t  w;
      cnt_t e;
      passes = 0;
      total  = 0;
      do begin
         removed = 0;
         for (int r = 0; r < NR; r++) begin
            gn[r] = gm[r];
            for (int c = 0; c < GW; c++) begin
               if (gm[r][c]) begin
                  n = 0;
                  for (int dr = -1; dr <= 1; dr++)
                     for (int dc = -1; dc <= 1; dc++)
                        if (dr != 0 || dc != 0) n += occ(r + dr, c + dc);
                  if (n < TH) begin
                     gn[r][c] = 1'b0;
                     removed++;
                  end
               end
            end
         end
         for (int r = 0; r < NR; r++)
            for (int k = 0; k < KC; k++)
               if (gn[r][k*TW +: TW] != gm[r][k*TW +: TW]) begin
                  w.r = r;
                  w.c = k;
                  w.d = int'(gn[r][k*TW +: TW]);
                  exp_wr.push_back(w);
               end
         for (int r = 0; r < NR; r++) gm[r] = gn[r];
         passes++;
         total += removed;
      end while (iter != 0 && removed != 0 && passes < MAXP);
      e.prem = removed;
      e.rtot = total;
      e.pcnt = passes;
      exp_cnt.push_back(e);
   endtask

   // Memory responder with random ack latency; every write is popped against the expected write stream.
   initial begin
      wr_t w;
      for (int k = 0; k < 2; k++) begin
         ack[k]   = 1'b0;
         rdata[k] = '0;
         dly[k]   = 0;
      end
      forever begin
         @(negedge clock);
         for (int k = 0; k < 2; k++) begin
            ack[k] = 1'b0;
            if (reset) begin
               dly[k] = 0;
            end else if (req[k]) begin
               if (dly[k] > 0) begin
                  dly[k]--;
               end else begin
                  ack[k] = 1'b1;
                  chk("addr_range", int'(int'(row[k]) < NR), 1);
                  if (we[k]) begin
                     if (exp_wr.size() == 0) begin
                        chk("unexpected_write_row", int'(row[k]), -1);
                     end else begin
                        w = exp_wr.pop_front();
                        chk("wr_row",  int'(row[k]),   w.r);
                        chk("wr_col",  int'(col[k]),   w.c);
                        chk("wr_data", int'(wdata[k]), w.d);
                     end
                     if (int'(row[k]) < NR) mem[k][row[k]][int'(col[k])*TW +: TW] = wdata[k];
                  end else if (int'(row[k]) < NR) begin
                     rdata[k] = mem[k][row[k]][int'(col[k])*TW +: TW];
                  end
                  dly[k] = (maxd == 0) ? 0 : int'($urandom_range(maxd, 0));
               end
            end
         end
      end
   end

   // Completion monitor: counters on every done pulse.
   initial begin
      cnt_t e;
      forever begin
         @(negedge clock);
         for (int k = 0; k < 2; k++) begin
            if (done[k]) begin
               done_seen++;
               if (exp_cnt.size() == 0) begin
                  chk("unexpected_done", 1, 0);
               end else begin
                  e = exp_cnt.pop_front();
                  chk("pass_removed",  int'(prem[k]), e.prem);
                  chk("removed_total", int'(rtot[k]), e.rtot);
                  chk("pass_count",    int'(pcnt[k]), e.pcnt);
               end
            end
         end
      end
   end

   task automatic chk_idle(input int k, input string tag);
      chk({tag, "_busy"},  int'(busy[k]),  0);
      chk({tag, "_done"},  int'(done[k]),  0);
      chk({tag, "_req"},   int'(req[k]),   0);
      chk({tag, "_we"},    int'(we[k]),    0);
      chk({tag, "_row"},   int'(row[k]),   0);
      chk({tag, "_col"},   int'(col[k]),   0);
      chk({tag, "_wdata"}, int'(wdata[k]), 0);
      chk({tag, "_prem"},  int'(prem[k]),  0);
      chk({tag, "_rtot"},  int'(rtot[k]),  0);
      chk({tag, "_pcnt"},  int'(pcnt[k]),  0);
   endtask

   task automatic pulse(input int k);
      start[k] = 1'b1;
      @(negedge clock);
      start[k] = 1'b0;
      chk("busy_after_start", int'(busy[k]), 1);
   endtask

   task automatic clear_g();
      for (int r = 0; r < NR; r++) gm[r] = '0;
   endtask

   task automatic run(input int k, input int iter, input int md, input bit abort);
      int t;
      maxd = md;
      for (int r = 0; r < NR; r++) mem[k][r] = gm[r];
      exp_wr.delete();
      exp_cnt.delete();
      model(iter);
      done_seen = 0;
      pulse(k);
      if (abort) begin
         t = 0;
         while (!(req[k] && !we[k] && row[k] == AW'(1)) && t < 5000) begin
            @(negedge clock);
            t++;
         end
         chk("reach_load_row1", int'(t < 5000), 1);
         reset = 1'b1;
         #1;
         chk_idle(k, "midrst");
         @(negedge clock);
         @(negedge clock);
         reset = 1'b0;
         @(negedge clock);
         pulse(k);
      end
      t = 0;
      while (done_seen == 0 && t < 20000) begin
         @(negedge clock);
         t++;
      end
      chk("done_seen", int'(done_seen != 0), 1);
      repeat (3) @(negedge clock);
      chk("done_pulses", done_seen, 1);
      chk("writes_left", exp_wr.size(), 0);
      chk("busy_after_done", int'(busy[k]), 0);
      for (int r = 0; r < NR; r++) chk($sformatf("mem_row%0d", r), int'(mem[k][r]), int'(gm[r]));
   endtask

   initial begin
      reset    = 1'b1;
      start[0] = 1'b0;
      start[1] = 1'b0;
      repeat (3) @(negedge clock);
      chk_idle(0, "rst");
      chk_idle(1, "rst1");
      reset = 1'b0;
      @(negedge clock);

      // Empty grid: one pass, no writes.
      clear_g();
      run(0, 1, 0, 1'b0);

      // Isolated corner cell.
      clear_g();
      gm[0][0] = 1'b1;
      run(0, 1, 0, 1'b0);

      // 3x3 block at rows 1-3, cols 1-3, iterating then single pass.
      clear_g();
      for (int r = 1; r <= 3; r++) gm[r][3:1] = 3'b111;
      run(0, 1, 0, 1'b0);
      clear_g();
      for (int r = 1; r <= 3; r++) gm[r][3:1] = 3'b111;
      run(1, 0, 0, 1'b0);

      // Run straddling the chunk boundary.
      clear_g();
      gm[0][17:14] = 4'hF;
      run(0, 1, 2, 1'b0);

      // Random grid: zero-wait, random latency, single pass.
      for (int r = 0; r < NR; r++) gsave[r] = $urandom();
      for (int r = 0; r < NR; r++) gm[r] = gsave[r];
      run(0, 1, 0, 1'b0);
      for (int r = 0; r < NR; r++) gm[r] = gsave[r];
      run(0, 1, 5, 1'b0);
      for (int r = 0; r < NR; r++) gm[r] = gsave[r];
      run(1, 0, 5, 1'b0);

      // Denser random grid with reset during a row load, then a restart.
      for (int r = 0; r < NR; r++) gsave[r] = $urandom() | $urandom();
      for (int r = 0; r < NR; r++) gm[r] = gsave[r];
      run(0, 1, 5, 1'b1);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
